// File: rtl/fr_2_current_rand_mc_pkg.sv
// Shared constants, FSM state type and the float multiply / floor / saturating
// shift helpers used by the multi-channel rate-to-current converter.
package fr_2_current_rand_mc_pkg;

  localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;
  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] FLOAT_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  // float32 multiply, round-to-nearest-even; denormals flush to zero
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [23:0]       m;
    logic              g, st;
    logic [24:0]       mr;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return FLOAT_QNAN;
    if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {s, 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr = {1'b0, m} + {24'd0, g & (st | m[0])};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
    if (e <= 10'sd0) return {s, 31'd0};
    return {s, e[7:0], mr[22:0]};
  endfunction

  // floor to int32; NaN/Inf and positive overflow give INT32_MAX,
  // negative finite overflow gives INT32_MIN
  function automatic logic [31:0] floor_i32(input logic [31:0] f);
    logic [7:0]  ex;
    logic [31:0] m32, mag, mask;
    logic        fr;
    ex = f[30:23];
    if (ex == 8'hFF) return INT32_MAX;
    if (ex == 8'h00) return '0;
    if (ex < 8'd127) return f[31] ? '1 : '0;
    if (ex >= 8'd158) return f[31] ? INT32_MIN : INT32_MAX;
    ex  = ex - 8'd127;
    m32 = {8'd0, 1'b1, f[22:0]};
    if (ex >= 8'd23) begin
      mag = m32 << (ex - 8'd23);
      fr  = 1'b0;
    end else begin
      mask = (32'd1 << (8'd23 - ex)) - 32'd1;
      mag  = m32 >> (8'd23 - ex);
      fr   = |(m32 & mask);
    end
    if (f[31]) return -(mag + {31'd0, fr});
    return mag;
  endfunction

  function automatic logic [31:0] sat_shl(input logic [31:0] v, input int unsigned sh);
    logic signed [63:0] w;
    w = {{32{v[31]}}, v} << sh;
    if (w > 64'sh0000_0000_7FFF_FFFF) return INT32_MAX;
    if (w < 64'shFFFF_FFFF_8000_0000) return INT32_MIN;
    return w[31:0];
  endfunction

endpackage

// File: rtl/fr_2_current_rand_mc_lfsr32.sv
// 32-bit Galois LFSR with synchronous reset to SEED and an advance enable.
module fr2i_lfsr32
  import fr_2_current_rand_mc_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] state
);

  always_ff @(posedge clk) begin
    if (rst) state <= SEED;
    else if (en) state <= state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
  end

endmodule

// File: rtl/fr_2_current_rand_mc.sv
// Multi-channel float rate to fixed-point current converter with per-channel
// random gain, using one shared 3-stage multiply/floor pipeline.
module fr_2_current_rand_mc
  import fr_2_current_rand_mc_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned NOISE_BITS = 20,
  parameter int unsigned SHIFT      = 6,
  parameter logic [31:0] SEED       = 32'hACE1_2468
) (
  input  logic              neuron_clk,
  input  logic              reset_global,
  input  logic              start,
  input  logic              noise_en,
  input  logic [N_CH*32-1:0] f_rawfr_in,
  output logic              busy,
  output logic              done,
  output logic [N_CH*32-1:0] i_current_out
);

  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);
  localparam logic [31:0] NMASK = (32'd1 << NOISE_BITS) - 32'd1;

  state_t        state_q, state_d;
  logic [31:0]   snap [N_CH];
  logic          snap_noise;
  logic [CW-1:0] ch;
  logic          drain;
  logic [31:0]   lfsr;
  logic [31:0]   gain;
  logic [22:0]   noise_mant;

  logic          s1_v, s2_v;
  logic [31:0]   s1_a, s1_b, s2_p;
  logic [CW-1:0] s1_ch, s2_ch;
  logic [31:0]   cur [N_CH];

  fr2i_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk   (neuron_clk),
    .rst   (reset_global),
    .en    (state_q == ISSUE),
    .state (lfsr)
  );

  // LFSR bits land in the top of the mantissa; NOISE_BITS=0 leaves gain at 1.0
  assign noise_mant = 23'((lfsr & NMASK) << (23 - NOISE_BITS));
  assign gain       = snap_noise ? {1'b0, 8'h7F, noise_mant} : FLOAT_ONE;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: if (ch == LAST) state_d = DRAIN;
      DRAIN: if (drain) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge neuron_clk) begin
    if (reset_global) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_ff @(posedge neuron_clk) begin
    if (reset_global) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        snap[k] <= '0;
        cur[k]  <= '0;
      end
      snap_noise <= 1'b0;
      ch         <= '0;
      drain      <= 1'b0;
      done       <= 1'b0;
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_ch      <= '0;
      s2_p       <= '0;
      s2_ch      <= '0;
    end else begin
      done <= (state_q == FIN);
      if (state_q == IDLE && start) begin
        for (int unsigned k = 0; k < N_CH; k++) snap[k] <= f_rawfr_in[32*k +: 32];
        snap_noise <= noise_en;
        ch         <= '0;
      end
      if (state_q == ISSUE) begin
        ch    <= ch + 1'b1;
        drain <= 1'b0;
      end
      if (state_q == DRAIN) drain <= 1'b1;

      s1_v  <= (state_q == ISSUE);
      s1_a  <= snap[ch];
      s1_b  <= gain;
      s1_ch <= ch;

      s2_v  <= s1_v;
      s2_p  <= fmul(s1_a, s1_b);
      s2_ch <= s1_ch;

      if (s2_v) cur[s2_ch] <= sat_shl(floor_i32(s2_p), SHIFT);
    end
  end

  assign busy = (state_q != IDLE);

  for (genvar k = 0; k < N_CH; k++) begin : g_out
    assign i_current_out[32*k +: 32] = cur[k];
  end

endmodule

// File: doc/fr_2_current_rand_mc.md
Name: fr_2_current_rand_mc

Overview:
- Multi-channel successor to the single-channel rate-to-current converter.
- Converts N_CH float32 firing rates into fixed-point synaptic currents, each scaled by an independent random gain in [1.0, 2.0).
- Uses one time-multiplexed float multiply + floor datapath that walks the channels round-robin on a start pulse.
- Noise can be disabled at run time (exact gain 1.0). Sits between spindle/afferent rate outputs and motoneuron current inputs.

Parameters:
- N_CH, 4, number of channels (1..16)
- NOISE_BITS, 20, LFSR bits placed in the top of the gain mantissa (0..23; 0 means gain is always 1.0)
- SHIFT, 6, left shift applied to the floored integer (0..15)
- SEED, 32'hACE1_2468, LFSR reset value (must be non-zero)

Ports:
- neuron_clk  in  1  clock
- reset_global  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to convert all channels
- noise_en  in  1  1 = random gain, 0 = gain exactly 1.0 (sampled with start)
- f_rawfr_in  in  N_CH*32  float32 rates; channel k is bits [32k+31:32k]
- busy  out  1  high while a conversion run is in progress
- done  out  1  one-cycle pulse when all outputs are updated
- i_current_out  out  N_CH*32  signed currents; channel k is bits [32k+31:32k]

Behaviour:
- One clock and one reset: neuron_clk, with reset_global synchronous and active-high. All state changes only on the rising edge of neuron_clk.
- Reset: busy=0, done=0, all i_current_out=0, LFSR=SEED, FSM=IDLE, and the snapshot registers are cleared.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - If start=1, snapshot f_rawfr_in and noise_en into registers, clear the channel counter, set busy=1, go to ISSUE.
  - If start=0, stay in IDLE.
- ISSUE:
  - Each cycle, present snapshot[ch] and the gain to the stage-1 register. Then ch++ and advance the LFSR one step.
  - After issuing ch=N_CH-1, go to DRAIN.
- DRAIN: wait 2 cycles for the pipeline to empty, then go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- Start is ignored while busy=1; no queuing. A start in the FIN cycle is also ignored.
- Gain word:
  - noise_en=1: {1'b0, 8'h7F, lfsr[NOISE_BITS-1:0], (23-NOISE_BITS) zeros}.
  - noise_en=0: 32'h3F80_0000.
- Pipeline: S1 registers the operands. S2 registers the float product. S3 computes floor(product) to signed int32, then shifts left by SHIFT, then writes i_current_out[ch] (per-channel write enable).
- Latency: the start cycle is cycle 0, first issue is cycle 1, done is asserted at cycle N_CH+4. busy is high for cycles 1..N_CH+3.
- Output hold: each channel output holds its value between runs and changes only in its own S3 write cycle.
- Floor and saturation:
  - Floor rounds toward negative infinity.
  - If |product| ≥ 2^31, NaN, or Inf: saturate to 32'h7FFF_FFFF, or 32'h8000_0000 for negative finite values.
  - Post-shift overflow saturates the same way; there is no wrap-around.
- Denormal input or zero input gives 0.
- LFSR: 32-bit Galois with taps 0x8020_0003. It advances only in ISSUE cycles, so the random sequence per run is deterministic from SEED.
- Reset mid-run: all outputs return to 0 on the next edge, in-flight pipeline data is discarded, and no done pulse is produced.

Decomposition:
- Shared package holds:
  - FLOAT_ONE = 32'h3F80_0000
  - INT32_MAX and INT32_MIN
  - LFSR_TAPS
  - FSM state typedef
- Existing float mult and floor modules are reused unchanged.
- One new sub-module, fr2i_lfsr32: synchronous reset to SEED, advance enable, 32-bit state output.

Test Plan:
- noise_en=0, SHIFT=6, all channels 10.0 (0x4120_0000), start pulse -> every output is 640 (0x0000_0280); done pulse at start+N_CH+4 (start+8 for N_CH=4).
- noise_en=0, channels {0.0, 2.5, 1.0e9, -3.5} -> outputs {0, 128, 0x7FFF_FFFF, -256}.
- noise_en=1, NOISE_BITS=20, all channels 10.0 -> each output is in [640, 1216], is a multiple of 64, matches the golden LFSR model from SEED, and channels differ.
- start pulsed on the cycle after an accepted start, and in the FIN cycle -> ignored; exactly one done pulse; next valid start reproduces the expected LFSR continuation.
- reset_global asserted for 1 cycle at start+3 -> all outputs 0, busy=0, no done pulse; a later run reproduces the SEED-based first-run values.
- NOISE_BITS=0, noise_en=1, channel 7.9 -> output 448 (gain is exactly 1.0).
